// File: rtl/mem_req_initiator.sv
// Master-side sequencer between the core load/store port and the single-port data memory:
// single-word stores, incrementing load bursts with a fixed memory read latency.
module mem_req_initiator #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned MAX_LEN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [AW-1:0]    req_addr,
    input  logic [3:0]       req_len,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_last,
    output logic             mem_write,
    output logic             mem_mode,
    output logic [AW-1:0]    mem_waddr,
    output logic [AW-1:0]    mem_raddr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    localparam int unsigned BW = 5;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STORE     = 2'd1,
        LOAD_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t          state;
    logic [BW-1:0]   beats;
    logic [CW-1:0]   lat_cnt;
    logic            req_fire;
    logic [BW-1:0]   load_beats;

    assign req_fire = req_valid && req_ready;

    // Oversized bursts are clamped to MAX_LEN beats.
    assign load_beats = (32'(req_len) >= MAX_LEN) ? BW'(MAX_LEN) : (BW'(req_len) + BW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beats     <= '0;
            lat_cnt   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
            mem_write <= 1'b0;
            mem_mode  <= 1'b0;
            mem_waddr <= '0;
            mem_raddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_store) begin
                            mem_waddr <= req_addr;
                            mem_wdata <= req_wdata;
                            mem_write <= 1'b1;
                            mem_mode  <= 1'b0;
                            state     <= STORE;
                        end else begin
                            mem_raddr <= req_addr;
                            mem_mode  <= 1'b1;
                            beats     <= load_beats;
                            lat_cnt   <= '0;
                            state     <= LOAD_WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                STORE: begin
                    mem_write <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                // Memory data is sampled on the RD_LAT-th edge after the address was set.
                LOAD_WAIT: begin
                    if (lat_cnt == CW'(RD_LAT - 1)) begin
                        rsp_rdata <= mem_rdata;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (beats == BW'(1));
                        lat_cnt   <= '0;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            mem_mode  <= 1'b0;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            beats     <= beats - BW'(1);
                            mem_raddr <= mem_raddr + AW'(1);
                            lat_cnt   <= '0;
                            state     <= LOAD_WAIT;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Scoreboarded bench for mem_req_initiator: directed scenarios plus random load/store traffic
// against a request-level memory model.
module tb_mem_req_initiator;

    localparam int unsigned W   = 32;
    localparam int unsigned D   = 32;
    localparam int unsigned A   = 5;
    localparam int unsigned LAT = 1;
    localparam int unsigned ML  = 8;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_store;
    logic [A-1:0] req_addr;
    logic [3:0]   req_len;
    logic [W-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         rsp_last;
    logic         mem_write;
    logic         mem_mode;
    logic [A-1:0] mem_waddr;
    logic [A-1:0] mem_raddr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         busy;

    mem_req_initiator #(
        .WIDTH(W), .DEPTH(D), .AW(A), .RD_LAT(LAT), .MAX_LEN(ML)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .mem_write(mem_write), .mem_mode(mem_mode),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array attached to the DUT pins; read data follows the read address.
    logic [W-1:0] mem_arr [D];
    logic         mem_clear;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(D); i++) mem_arr[i] <= '0;
        end else if (mem_write) begin
            mem_arr[mem_waddr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_arr[mem_raddr];

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] ref_mem [D];
    int           n_checks;
    int           n_pass;
    int           beats_seen;
    int           rdy_mode;
    bit           inv_en;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: picks rsp_ready, checks hold stability and pops the scoreboard on each handshake.
    initial begin
        bit           hold;
        logic [W-1:0] h_data;
        logic         h_last;
        logic [A-1:0] h_raddr;
        beat_t        b;
        hold = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                check("write_during_read", 64'(mem_write & mem_mode), 64'd0);
                if (inv_en) check("busy_vs_ready", 64'(busy), 64'(!req_ready));
                if (hold) begin
                    check("hold_valid", 64'(rsp_valid), 64'd1);
                    check("hold_rdata", 64'(rsp_rdata), 64'(h_data));
                    check("hold_last", 64'(rsp_last), 64'(h_last));
                    check("hold_raddr", 64'(mem_raddr), 64'(h_raddr));
                end
                case (rdy_mode)
                    1:       rsp_ready = 1'b0;
                    2:       rsp_ready = 1'b1;
                    default: rsp_ready = ($urandom_range(0, 3) != 0);
                endcase
                if (rsp_valid && rsp_ready) begin
                    hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(rsp_rdata), 64'hDEAD_BEEF_0000_0000);
                    end else begin
                        b = exp_q.pop_front();
                        check("rsp_rdata", 64'(rsp_rdata), 64'(b.data));
                        check("rsp_last", 64'(rsp_last), 64'(b.last));
                    end
                    beats_seen++;
                end else if (rsp_valid) begin
                    hold    = 1'b1;
                    h_data  = rsp_rdata;
                    h_last  = rsp_last;
                    h_raddr = mem_raddr;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    // Present one request, wait for its accept, record the expected effect, check the pin activity.
    task automatic issue(input bit st, input int addr, input int len, input logic [W-1:0] wd);
        int    cnt;
        int    n;
        beat_t b;
        req_valid = 1'b1;
        req_store = st;
        req_addr  = A'(addr);
        req_len   = 4'(len);
        req_wdata = wd;
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 500) begin
            timeout("req_accept");
            req_valid = 1'b0;
            return;
        end
        if (st) begin
            ref_mem[addr] = wd;
        end else begin
            n = (len >= int'(ML)) ? int'(ML) : len + 1;
            for (int i = 0; i < n; i++) begin
                b.data = ref_mem[(addr + i) % int'(D)];
                b.last = (i == n - 1);
                exp_q.push_back(b);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_ready_low", 64'(req_ready), 64'd0);
        if (st) begin
            check("store_write", 64'(mem_write), 64'd1);
            check("store_waddr", 64'(mem_waddr), 64'(addr));
            check("store_wdata", 64'(mem_wdata), 64'(wd));
            check("store_mode", 64'(mem_mode), 64'd0);
            @(negedge clk);
            check("store_write_end", 64'(mem_write), 64'd0);
            check("store_ready_back", 64'(req_ready), 64'd1);
        end else begin
            check("load_mode", 64'(mem_mode), 64'd1);
            check("load_raddr", 64'(mem_raddr), 64'(addr));
        end
    endtask

    task automatic wait_beats(input int target);
        int cnt;
        cnt = 0;
        while (beats_seen < target && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 500) timeout("wait_beats");
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 3000) timeout("drain");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int b0;
        n_checks   = 0;
        n_pass     = 0;
        beats_seen = 0;
        rdy_mode   = 2;
        inv_en     = 1'b0;
        mem_clear  = 1'b1;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_wdata  = '0;
        for (int i = 0; i < int'(D); i++) ref_mem[i] = '0;

        // Reset pulse and first ready edge
        #1 reset = 1'b1;
        #1;
        check("reset_outputs_zero", 64'(|{req_ready, rsp_valid, rsp_rdata, rsp_last, mem_write,
              mem_mode, mem_waddr, mem_raddr, mem_wdata, busy}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_clear = 1'b0;
        #1 check("ready_before_edge", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("ready_after_edge", 64'(req_ready), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        inv_en = 1'b1;

        // Store then single-beat load of the same word, with first-beat latency
        issue(1'b1, 13, 0, 32'd134);
        issue(1'b0, 13, 0, 32'd0);
        @(negedge clk);
        check("load_latency_valid", 64'(rsp_valid), 64'd1);
        drain();

        // Three back-to-back stores, 3-beat burst
        issue(1'b1, 10, 0, 32'd144);
        issue(1'b1, 11, 0, 32'd170);
        issue(1'b1, 12, 0, 32'd200);
        issue(1'b0, 10, 2, 32'd0);
        drain();

        // Burst wrapping past the top address
        issue(1'b1, 31, 0, 32'd5);
        issue(1'b1, 0, 0, 32'd9);
        issue(1'b0, 31, 1, 32'd0);
        drain();

        // Consumer stalls beat 2 for several cycles
        b0 = beats_seen;
        issue(1'b0, 10, 3, 32'd0);
        wait_beats(b0 + 1);
        rdy_mode = 1;
        cnt = 0;
        while (rsp_valid !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) timeout("stall_beat");
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        drain();

        // Length clamp: 16 requested beats yield MAX_LEN
        issue(1'b0, 4, 15, 32'd0);
        drain();

        // Reset in the middle of a burst drops it
        issue(1'b1, 13, 0, 32'd201);
        b0 = beats_seen;
        issue(1'b0, 10, 3, 32'd0);
        wait_beats(b0 + 1);
        inv_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midburst_reset_zero", 64'(|{req_ready, rsp_valid, rsp_rdata, rsp_last, mem_write,
              mem_mode, mem_waddr, mem_raddr, mem_wdata, busy}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check("ready_low_after_reset", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("ready_high_after_reset", 64'(req_ready), 64'd1);
        inv_en = 1'b1;
        issue(1'b0, 13, 0, 32'd0);
        drain();

        // Random traffic with random consumer backpressure
        rdy_mode = 0;
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'(($urandom_range(0, 1))), int'($urandom_range(0, D - 1)),
                  int'($urandom_range(0, 15)), $urandom);
        end
        drain();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'(busy), 64'd0);
        check("final_no_rsp", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
